// File: rtl/axis_tx_pkg.sv
// Shared types for the AXI-Stream packet transmitter: packetiser state and
// the two ways TLAST can be produced.
package axis_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } tx_state_e;

  localparam int LM_FLAG  = 0;
  localparam int LM_COUNT = 1;

endpackage

// File: rtl/axis_tx_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata whenever
// empty is low. Pointers wrap naturally because DEPTH is a power of two.
module axis_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axis_packet_tx.sv
// AXI-Stream packet transmitter: packetises upstream beats (sof/last, routing)
// and buffers them in a FWFT FIFO. Define AXIS_TX_PKT_CNT_EN to add pkt_cnt.
module axis_packet_tx
  import axis_tx_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 7,
  parameter int DEST_W   = 1,
  parameter int LEN_W    = 8,
  parameter int LEN_MODE = LM_FLAG
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [DATA_W/8-1:0]     in_keep,
  input  logic                    in_last,
  input  logic [LEN_W-1:0]        pkt_len,
  input  logic [ID_W-1:0]         cfg_id,
  input  logic [DEST_W-1:0]       cfg_dest,
  output logic                    TVALID,
  output logic                    TLAST,
  output logic                    TUSER,
  output logic [DATA_W-1:0]       TDATA,
  output logic [DATA_W/8-1:0]     TKEEP,
  output logic [DATA_W/8-1:0]     TSTRB,
  output logic [ID_W-1:0]         TID,
  output logic [DEST_W-1:0]       TDEST,
  input  logic                    TREADY,
  output logic [$clog2(DEPTH):0]  level
`ifdef AXIS_TX_PKT_CNT_EN
  ,
  output logic [31:0]             pkt_cnt
`endif
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 2 + ID_W + DEST_W;

  tx_state_e          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DEST_W-1:0]  dest_q, dest_d;

  logic               accept, first_beat, cnt_last, beat_last;
  logic [LEN_W-1:0]   len_cur, len_eff;
  logic [ID_W-1:0]    beat_id;
  logic [DEST_W-1:0]  beat_dest;
  logic               fifo_full, fifo_empty, do_pop;
  logic [ENTRY_W-1:0] wr_entry, head;

  assign in_ready = ARESETn && !fifo_full;
  assign accept   = in_valid && in_ready;

  // Routing and length come from the cfg inputs on the first beat and from
  // the sampled copies for the rest of the packet.
  always_comb begin
    first_beat = (state_q == IDLE);
    len_cur    = first_beat ? pkt_len : len_q;
    len_eff    = (len_cur == '0) ? LEN_W'(1) : len_cur;
    cnt_last   = (cnt_q == len_eff - LEN_W'(1));
    beat_last  = (LEN_MODE == LM_COUNT) ? cnt_last : in_last;
    beat_id    = first_beat ? cfg_id : id_q;
    beat_dest  = first_beat ? cfg_dest : dest_q;

    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    dest_d  = dest_q;
    if (accept) begin
      len_d  = len_cur;
      id_d   = beat_id;
      dest_d = beat_dest;
      if (beat_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = BODY;
        cnt_d   = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
    end
  end

  assign wr_entry = {in_data, in_keep, beat_last, first_beat, beat_id, beat_dest};
  assign do_pop   = !fifo_empty && TREADY;

  axis_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (do_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Gating by TVALID keeps every T* output at zero while empty or in reset.
  assign TVALID = !fifo_empty;
  always_comb begin
    {TDATA, TKEEP, TLAST, TUSER, TID, TDEST} = '0;
    if (TVALID) {TDATA, TKEEP, TLAST, TUSER, TID, TDEST} = head;
  end
  assign TSTRB = TKEEP;

`ifdef AXIS_TX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (TVALID && TREADY && TLAST) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  // Packet counter not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_packet_tx.sv
// Scoreboard bench for axis_packet_tx: one flag-mode and one count-mode
// instance; expected beats are queued on acceptance and checked on output.
module tb_axis_packet_tx;
  import axis_tx_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic        user;
    logic [6:0]  id;
    logic [0:0]  dest;
  } beat_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  beat_t q0[$];
  beat_t q1[$];

  // Instance 0: TLAST from in_last
  logic        in_valid0 = 0, in_ready0, in_last0 = 0, TREADY0 = 0;
  logic [15:0] in_data0 = 0;
  logic [1:0]  in_keep0 = 0;
  logic [7:0]  pkt_len0 = 0;
  logic [6:0]  cfg_id0 = 0;
  logic [0:0]  cfg_dest0 = 0;
  logic        TVALID0, TLAST0, TUSER0;
  logic [15:0] TDATA0;
  logic [1:0]  TKEEP0, TSTRB0;
  logic [6:0]  TID0;
  logic [0:0]  TDEST0;
  logic [2:0]  level0;
`ifdef AXIS_TX_PKT_CNT_EN
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;
`endif

  // Instance 1: TLAST from pkt_len
  logic        in_valid1 = 0, in_ready1, in_last1 = 0, TREADY1 = 0;
  logic [15:0] in_data1 = 0;
  logic [1:0]  in_keep1 = 2'b01;
  logic [7:0]  pkt_len1 = 0;
  logic [6:0]  cfg_id1 = 7'd42;
  logic [0:0]  cfg_dest1 = 1'b0;
  logic        TVALID1, TLAST1, TUSER1;
  logic [15:0] TDATA1;
  logic [1:0]  TKEEP1, TSTRB1;
  logic [6:0]  TID1;
  logic [0:0]  TDEST1;
  logic [2:0]  level1;

  axis_packet_tx #(.DATA_W(16), .DEPTH(4), .ID_W(7), .DEST_W(1), .LEN_W(8), .LEN_MODE(LM_FLAG)) dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_keep(in_keep0), .in_last(in_last0), .pkt_len(pkt_len0),
    .cfg_id(cfg_id0), .cfg_dest(cfg_dest0), .TVALID(TVALID0), .TLAST(TLAST0),
    .TUSER(TUSER0), .TDATA(TDATA0), .TKEEP(TKEEP0), .TSTRB(TSTRB0), .TID(TID0),
    .TDEST(TDEST0), .TREADY(TREADY0), .level(level0)
`ifdef AXIS_TX_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt0)
`endif
  );

  axis_packet_tx #(.DATA_W(16), .DEPTH(4), .ID_W(7), .DEST_W(1), .LEN_W(8), .LEN_MODE(LM_COUNT)) dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_keep(in_keep1), .in_last(in_last1), .pkt_len(pkt_len1),
    .cfg_id(cfg_id1), .cfg_dest(cfg_dest1), .TVALID(TVALID1), .TLAST(TLAST1),
    .TUSER(TUSER1), .TDATA(TDATA1), .TKEEP(TKEEP1), .TSTRB(TSTRB1), .TID(TID1),
    .TDEST(TDEST1), .TREADY(TREADY1), .level(level1)
`ifdef AXIS_TX_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: no in_ready within budget", name);
  endtask

  // Monitors: pop the expected beat whenever a handshake is about to happen.
  always @(negedge ACLK) begin
    if (ARESETn && TVALID0 && TREADY0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("[TB] FAIL beat0: got data 0x%0h expected no beat", TDATA0);
      end else begin
        beat_t e, a;
        e = q0.pop_front();
        a = '{TDATA0, TKEEP0, TLAST0, TUSER0, TID0, TDEST0};
        if (a !== e || TSTRB0 !== e.keep) begin
          bad++;
          $display("[TB] FAIL beat0: got 0x%0h strb %b expected 0x%0h", a, TSTRB0, e);
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (ARESETn && TVALID1 && TREADY1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("[TB] FAIL beat1: got data 0x%0h expected no beat", TDATA1);
      end else begin
        beat_t e, a;
        e = q1.pop_front();
        a = '{TDATA1, TKEEP1, TLAST1, TUSER1, TID1, TDEST1};
        if (a !== e || TSTRB1 !== e.keep) begin
          bad++;
          $display("[TB] FAIL beat1: got 0x%0h strb %b expected 0x%0h", a, TSTRB1, e);
        end
      end
    end
  end

  // Drives one beat on instance 0, leaves in_valid high; called just after a posedge.
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] k, input logic l,
                               input logic [6:0] id, input logic dst,
                               input logic eu, input logic el, input logic [6:0] eid, input logic ed);
    int waited = 0;
    in_valid0 = 1'b1; in_data0 = d; in_keep0 = k; in_last0 = l; cfg_id0 = id; cfg_dest0 = dst;
    @(negedge ACLK);
    while (!in_ready0 && waited < 40) begin
      waited++;
      @(negedge ACLK);
    end
    if (!in_ready0) begin
      in_valid0 = 1'b0;
      timeoutFail("accept0");
    end else begin
      q0.push_back('{d, k, el, eu, eid, ed});
    end
    @(posedge ACLK); #1;
  endtask

  task automatic applyStimulus1(input logic [15:0] d, input logic l, input logic [7:0] len,
                                input logic eu, input logic el);
    int waited = 0;
    in_valid1 = 1'b1; in_data1 = d; in_last1 = l; pkt_len1 = len;
    @(negedge ACLK);
    while (!in_ready1 && waited < 40) begin
      waited++;
      @(negedge ACLK);
    end
    if (!in_ready1) begin
      in_valid1 = 1'b0;
      timeoutFail("accept1");
    end else begin
      q1.push_back('{d, 2'b01, el, eu, 7'd42, 1'b0});
    end
    @(posedge ACLK); #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("rst_tvalid", TVALID0, 0);
    checkOutput("rst_in_ready", in_ready0, 0);
    checkOutput("rst_level", level0, 0);
    checkOutput("rst_tdata", TDATA0, 0);
    #11 ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Ordered pass-through, sof on first, last on third
    TREADY0 = 1'b1;
    applyStimulus(16'd10000, 2'b11, 0, 7'd3, 1'b1, 1, 0, 7'd3, 1'b1);
    applyStimulus(16'd9999,  2'b01, 0, 7'd3, 1'b1, 0, 0, 7'd3, 1'b1);
    applyStimulus(16'd9998,  2'b10, 1, 7'd3, 1'b1, 0, 1, 7'd3, 1'b1);
    in_valid0 = 1'b0;
    waitCycles(1);
    checkOutput("drain_level", level0, 0);
    checkOutput("drain_tvalid", TVALID0, 0);

    // Back-pressure: fill to DEPTH, stall the fifth beat
    TREADY0 = 1'b0;
    applyStimulus(16'hA001, 2'b11, 0, 7'd3, 1'b0, 1, 0, 7'd3, 1'b0);
    applyStimulus(16'hA002, 2'b11, 0, 7'd3, 1'b0, 0, 0, 7'd3, 1'b0);
    applyStimulus(16'hA003, 2'b11, 0, 7'd3, 1'b0, 0, 0, 7'd3, 1'b0);
    applyStimulus(16'hA004, 2'b11, 0, 7'd3, 1'b0, 0, 0, 7'd3, 1'b0);
    in_data0 = 16'hA005; in_last0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checkOutput("full_in_ready", in_ready0, 0);
      checkOutput("full_level", level0, 4);
      checkOutput("stall_tdata", TDATA0, 16'hA001);
      @(posedge ACLK); #1;
    end
    TREADY0 = 1'b1;
    applyStimulus(16'hA005, 2'b11, 1, 7'd3, 1'b0, 0, 1, 7'd3, 1'b0);
    in_valid0 = 1'b0;
    waitCycles(5);
    checkOutput("bp_level", level0, 0);

    // Routing sampled on first beat only
    applyStimulus(16'hB001, 2'b11, 0, 7'd5, 1'b1, 1, 0, 7'd5, 1'b1);
    applyStimulus(16'hB002, 2'b11, 0, 7'd9, 1'b0, 0, 0, 7'd5, 1'b1);
    applyStimulus(16'hB003, 2'b11, 1, 7'd9, 1'b0, 0, 1, 7'd5, 1'b1);
    applyStimulus(16'hB004, 2'b01, 1, 7'd9, 1'b0, 1, 1, 7'd9, 1'b0);
    in_valid0 = 1'b0;
    waitCycles(2);

    // Count mode: pkt_len=3 over 7 continuous beats, in_last ignored
    TREADY1 = 1'b1;
    applyStimulus1(16'd1, 0, 8'd3, 1, 0);
    applyStimulus1(16'd2, 1, 8'd3, 0, 0);
    applyStimulus1(16'd3, 0, 8'd3, 0, 1);
    applyStimulus1(16'd4, 0, 8'd3, 1, 0);
    applyStimulus1(16'd5, 0, 8'd3, 0, 0);
    applyStimulus1(16'd6, 0, 8'd3, 0, 1);
    applyStimulus1(16'd7, 0, 8'd3, 1, 0);
    in_valid1 = 1'b0;
    waitCycles(2);
    checkOutput("cnt_level", level1, 0);
    // Packet 3 keeps its sampled length despite pkt_len changing
    applyStimulus1(16'd8, 0, 8'd1, 0, 0);
    applyStimulus1(16'd9, 0, 8'd1, 0, 1);
    applyStimulus1(16'd10, 0, 8'd0, 1, 1);
    applyStimulus1(16'd11, 0, 8'd2, 1, 0);
    applyStimulus1(16'd12, 0, 8'd2, 0, 1);
    in_valid1 = 1'b0;
    waitCycles(3);

    // Reset mid-packet with two beats buffered
    TREADY0 = 1'b0;
    applyStimulus(16'h3001, 2'b11, 0, 7'd3, 1'b0, 1, 0, 7'd3, 1'b0);
    applyStimulus(16'h3002, 2'b11, 0, 7'd3, 1'b0, 0, 0, 7'd3, 1'b0);
    in_valid0 = 1'b0;
    checkOutput("pre_rst_level", level0, 2);
    #2 ARESETn = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", TVALID0, 0);
    checkOutput("mid_rst_level", level0, 0);
    checkOutput("mid_rst_in_ready", in_ready0, 0);
    checkOutput("mid_rst_tdata", TDATA0, 0);
    checkOutput("mid_rst_tuser", TUSER0, 0);
    q0.delete();
    q1.delete();
    waitCycles(2);
    #2 ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // First beat after reset is sof; stalled TLAST is not counted yet
    applyStimulus(16'h5555, 2'b11, 1, 7'd3, 1'b0, 1, 1, 7'd3, 1'b0);
    in_valid0 = 1'b0;
    @(negedge ACLK);
    checkOutput("post_rst_tuser", TUSER0, 1);
    checkOutput("post_rst_tlast", TLAST0, 1);
`ifdef AXIS_TX_PKT_CNT_EN
    checkOutput("pkt_cnt_stalled", pkt_cnt0, 0);
`endif
    @(posedge ACLK); #1;
    TREADY0 = 1'b1;
    waitCycles(1);
`ifdef AXIS_TX_PKT_CNT_EN
    checkOutput("pkt_cnt_one", pkt_cnt0, 1);
`endif
    applyStimulus(16'h6001, 2'b11, 0, 7'd3, 1'b0, 1, 0, 7'd3, 1'b0);
    applyStimulus(16'h6002, 2'b11, 1, 7'd3, 1'b0, 0, 1, 7'd3, 1'b0);
    applyStimulus(16'h7001, 2'b11, 1, 7'd3, 1'b0, 1, 1, 7'd3, 1'b0);
    in_valid0 = 1'b0;
    waitCycles(3);
    checkOutput("final_level", level0, 0);
`ifdef AXIS_TX_PKT_CNT_EN
    checkOutput("pkt_cnt_three", pkt_cnt0, 3);
`endif

    checkOutput("q0_empty", q0.size(), 0);
    checkOutput("q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_tx.md
AXIS_PACKET_TX -- requirements
Module: axis_packet_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, TDATA width in bits; multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of 2, minimum 2.
REQ-003 SHALL have parameter ID_W, default 7, TID width.
REQ-004 SHALL have parameter DEST_W, default 1, TDEST width.
REQ-005 SHALL have parameter LEN_W, default 8, pkt_len width.
REQ-006 SHALL have parameter LEN_MODE, default 0: 0 = TLAST from in_last; 1 = TLAST generated after pkt_len beats.
REQ-007 ACLK  input  1  clock; all logic on rising edge.
REQ-008 ARESETn  input  1  asynchronous active-low reset.
REQ-009 in_valid  input  1  upstream beat valid.
REQ-010 in_ready  output  1  upstream beat accepted when in_valid && in_ready.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 in_keep  input  DATA_W/8  byte enables for this beat.
REQ-013 in_last  input  1  end of packet (LEN_MODE=0 only; ignored otherwise).
REQ-014 pkt_len  input  LEN_W  beats per packet (LEN_MODE=1).
REQ-015 cfg_id / cfg_dest  input  ID_W / DEST_W  stream routing for the next packet.
REQ-016 TVALID, TLAST, TUSER  output  1 each; TDATA  output  DATA_W; TKEEP, TSTRB  output  DATA_W/8; TID  output  ID_W; TDEST  output  DEST_W.
REQ-017 TREADY  input  1  downstream ready.
REQ-018 level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-019 SHALL buffer accepted beats in a DEPTH-entry FIFO storing {data, keep, last, sof, id, dest}.
REQ-020 in_ready SHALL equal !full; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-021 A beat accepted in cycle N SHALL appear on T* outputs from cycle N+1 (FWFT head).
REQ-022 TVALID SHALL equal !empty; the head SHALL pop on TVALID && TREADY.
REQ-023 While TVALID && !TREADY, all T* outputs SHALL hold stable.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-025 Packetiser FSM SHALL have states IDLE (no open packet) and BODY (packet open).
REQ-026 IDLE->BODY on an accepted beat that is not last; IDLE->IDLE on an accepted single-beat packet; BODY->IDLE on an accepted last beat; otherwise hold.
REQ-027 The first beat accepted in IDLE SHALL be stored with sof=1; TUSER SHALL output sof.
REQ-028 cfg_id, cfg_dest and pkt_len SHALL be sampled on the first beat of a packet and applied to every beat of that packet.
REQ-029 LEN_MODE=1: beat counter SHALL mark last when count == sampled pkt_len-1, then clear; pkt_len=0 SHALL be treated as 1.
REQ-030 TKEEP SHALL equal stored in_keep; TSTRB SHALL equal TKEEP.

Reset
REQ-031 ARESETn low SHALL immediately empty the FIFO, clear pointers, counter, level, and force IDLE.
REQ-032 During reset TVALID, TLAST, TUSER, TDATA, TKEEP, TSTRB, TID, TDEST SHALL be 0; in_ready SHALL be 0.
REQ-033 Reset mid-packet SHALL discard all buffered beats; the first beat after release SHALL carry sof=1.

Configuration
REQ-034 Macro AXIS_TX_PKT_CNT_EN defined: adds output pkt_cnt (32 bit), incremented on each TVALID && TREADY && TLAST, wrapping at 2^32, reset to 0.
REQ-035 Macro undefined: pkt_cnt port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-036 Package axis_tx_pkg SHALL hold the FSM state enum (IDLE, BODY) and LEN_MODE constants (LM_FLAG=0, LM_COUNT=1).
REQ-037 FIFO SHALL be sub-module axis_tx_fifo (parametrised width, DEPTH; FWFT, full/empty/level); packetiser and AXI-S mapping SHALL stay in top.

Verification
REQ-038 DATA_W=16, LEN_MODE=0, TREADY=1, beats 10000, 9999, 9998 with in_last on 9998 -> TDATA same order one cycle later, TUSER on 10000, TLAST on 9998.
REQ-039 TREADY=0, DEPTH=4, push 5 beats -> in_ready low after 4, level=4, TDATA held at first beat; TREADY=1 -> drain in order.
REQ-040 LEN_MODE=1, pkt_len=3, 7 continuous beats -> TLAST on beats 3 and 6; beat 7 pending with no TLAST; TUSER on beats 1, 4, 7.
REQ-041 cfg_id=5 at packet 1 start, changed to 9 mid-packet -> all packet-1 beats TID=5; packet 2 TID=9.
REQ-042 ARESETn pulsed low with 2 beats buffered mid-packet -> TVALID=0 immediately, level=0; next beat has TUSER=1.
REQ-043 AXIS_TX_PKT_CNT_EN defined, 3 packets drained -> pkt_cnt=3; stalled TLAST beat not counted until TREADY.
